// File: rtl/mycpu_mem_pkg.sv
// rtl/mycpu_mem_pkg.sv - shared types and constants for the myCPU memory arbiter
package mycpu_mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic INST = 1'b0;
   localparam logic DATA = 1'b1;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/mycpu_rr_arb2.sv
// rtl/mycpu_rr_arb2.sv - combinational two-way round-robin pick
// grant[0] selects the fetch requester, grant[1] the memory-stage requester.
module mycpu_rr_arb2
   import mycpu_mem_pkg::*;
(
   input  logic       req_inst,
   input  logic       req_data,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (req_inst && req_data) begin
         // On a collision the requester that did not win last time goes first.
         grant = (last_grant == INST) ? 2'b10 : 2'b01;
      end else begin
         grant = {req_data, req_inst};
      end
   end

endmodule

// File: rtl/mycpu_mem_arbiter.sv
// rtl/mycpu_mem_arbiter.sv - fetch/memory-stage arbiter for the single shared SRAM-like port
// One transaction in flight; addr_ok at acceptance, data_ok one cycle after the memory completes.
module mycpu_mem_arbiter
   import mycpu_mem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                inst_req,
   input  logic [ADDR_W-1:0]   inst_addr,
   output logic                inst_addr_ok,
   output logic                inst_data_ok,
   output logic [DATA_W-1:0]   inst_rdata,

   input  logic                data_req,
   input  logic                data_wr,
   input  logic [DATA_W/8-1:0] data_wstrb,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W-1:0]   data_wdata,
   output logic                data_addr_ok,
   output logic                data_data_ok,
   output logic [DATA_W-1:0]   data_rdata,

   output logic                mem_req,
   output logic                mem_wr,
   output logic [DATA_W/8-1:0] mem_wstrb,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_addr_ok,
   input  logic                mem_data_ok,
   input  logic [DATA_W-1:0]   mem_rdata
);

   state_t     state;
   state_t     next_state;
   logic       owner;
   logic       last_grant;
   logic [1:0] grant;
   logic       accept;
   logic       capture;

   mycpu_rr_arb2 u_arb (
      .req_inst   (inst_req),
      .req_data   (data_req),
      .last_grant (last_grant),
      .grant      (grant)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state   = state;
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      data_data_ok = 1'b0;
      mem_req      = 1'b0;
      capture      = 1'b0;
      case (state)
         IDLE: begin
            if (!rst && (grant != 2'b00)) begin
               inst_addr_ok = grant[0];
               data_addr_ok = grant[1];
               next_state   = ISSUE;
            end
         end
         ISSUE: begin
            mem_req = 1'b1;
            // A data_ok without addr_ok cannot belong to this request.
            if (mem_addr_ok) begin
               if (mem_data_ok) begin
                  capture    = 1'b1;
                  next_state = RESP;
               end else begin
                  next_state = WAIT;
               end
            end
         end
         WAIT: begin
            if (mem_data_ok) begin
               capture    = 1'b1;
               next_state = RESP;
            end
         end
         RESP: begin
            inst_data_ok = (owner == INST);
            data_data_ok = (owner == DATA);
            next_state   = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign accept = inst_addr_ok | data_addr_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_wr     <= 1'b0;
         mem_wstrb  <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         owner      <= INST;
         last_grant <= INST;
         inst_rdata <= '0;
         data_rdata <= '0;
      end else begin
         if (accept) begin
            owner      <= grant[1] ? DATA : INST;
            last_grant <= grant[1] ? DATA : INST;
            if (grant[1]) begin
               mem_wr    <= data_wr;
               mem_wstrb <= data_wstrb;
               mem_addr  <= data_addr;
               mem_wdata <= data_wdata;
            end else begin
               mem_wr    <= 1'b0;
               mem_wstrb <= '0;
               mem_addr  <= inst_addr;
               mem_wdata <= '0;
            end
         end
         // Writes return zero so the owner never sees stale bus data.
         if (capture) begin
            if (owner == DATA) begin
               data_rdata <= mem_wr ? {DATA_W{1'b0}} : mem_rdata;
            end else begin
               inst_rdata <= mem_wr ? {DATA_W{1'b0}} : mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mycpu_mem_arbiter.sv
// tb/tb_mycpu_mem_arbiter.sv - directed self-checking bench for mycpu_mem_arbiter
module tb_mycpu_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          inst_req;
   logic [AW-1:0] inst_addr;
   logic          inst_addr_ok;
   logic          inst_data_ok;
   logic [DW-1:0] inst_rdata;
   logic          data_req;
   logic          data_wr;
   logic [3:0]    data_wstrb;
   logic [AW-1:0] data_addr;
   logic [DW-1:0] data_wdata;
   logic          data_addr_ok;
   logic          data_data_ok;
   logic [DW-1:0] data_rdata;
   logic          mem_req;
   logic          mem_wr;
   logic [3:0]    mem_wstrb;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_addr_ok;
   logic          mem_data_ok;
   logic [DW-1:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   mycpu_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_wstrb   (data_wstrb),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .mem_req      (mem_req),
      .mem_wr       (mem_wr),
      .mem_wstrb    (mem_wstrb),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_addr_ok  (mem_addr_ok),
      .mem_data_ok  (mem_data_ok),
      .mem_rdata    (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      inst_req    = 1'b0;
      inst_addr   = '0;
      data_req    = 1'b0;
      data_wr     = 1'b0;
      data_wstrb  = '0;
      data_addr   = '0;
      data_wdata  = '0;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      mem_rdata   = '0;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      #1;
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_addr_ok", {data_addr_ok, inst_addr_ok}, 2'b00);
      check("rst_data_ok", {data_data_ok, inst_data_ok}, 2'b00);
      check("rst_rdata", {inst_rdata, data_rdata}, 64'h0);
      check("rst_mem_fields", {mem_wr, mem_wstrb, mem_addr}, 37'h0);
      inst_req = 1'b1;
      #1;
      check("rst_no_accept", inst_addr_ok, 1'b0);
      inst_req = 1'b0;
      rst = 1'b0;

      // single fetch: addr_ok in cycle 1, data_ok in cycle 3
      tick();
      inst_req  = 1'b1;
      inst_addr = 32'hBFC00000;
      #1;
      check("f_addr_ok", {data_addr_ok, inst_addr_ok}, 2'b01);
      tick();
      inst_req    = 1'b0;
      inst_addr   = '0;
      mem_addr_ok = 1'b1;
      #1;
      check("f_mem_req", mem_req, 1'b1);
      check("f_mem_addr", mem_addr, 32'hBFC00000);
      check("f_mem_wr", {mem_wr, mem_wstrb}, 5'h0);
      tick();
      mem_addr_ok = 1'b0;
      #1;
      check("f_wait_req", mem_req, 1'b0);
      tick();
      mem_data_ok = 1'b1;
      mem_rdata   = 32'h24080001;
      #1;
      check("f_no_early_ok", inst_data_ok, 1'b0);
      tick();
      mem_data_ok = 1'b0;
      mem_rdata   = '0;
      #1;
      check("f_data_ok", {data_data_ok, inst_data_ok}, 2'b01);
      check("f_rdata", inst_rdata, 32'h24080001);
      tick();
      #1;
      check("f_pulse", inst_data_ok, 1'b0);
      check("f_rdata_hold", inst_rdata, 32'h24080001);

      // data write with zero-wait memory carrying nonzero read data
      data_req   = 1'b1;
      data_wr    = 1'b1;
      data_wstrb = 4'hF;
      data_addr  = 32'h80001000;
      data_wdata = 32'hDEADBEEF;
      #1;
      check("w_addr_ok", {data_addr_ok, inst_addr_ok}, 2'b10);
      tick();
      idle_inputs();
      mem_addr_ok = 1'b1;
      mem_data_ok = 1'b1;
      mem_rdata   = 32'h55555555;
      #1;
      check("w_mem_ctl", {mem_req, mem_wr, mem_wstrb}, 6'h3F);
      check("w_mem_addr", mem_addr, 32'h80001000);
      check("w_mem_wdata", mem_wdata, 32'hDEADBEEF);
      tick();
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      #1;
      check("w_data_ok", {data_data_ok, inst_data_ok}, 2'b10);
      check("w_rdata_zero", data_rdata, 32'h0);
      check("w_inst_rdata", inst_rdata, 32'h24080001);
      tick();
      #1;
      check("w_pulse", data_data_ok, 1'b0);

      // reset restores last_grant, so the collision must start with DATA
      rst = 1'b1;
      tick();
      rst = 1'b0;
      inst_req    = 1'b1;
      inst_addr   = 32'h00000100;
      data_req    = 1'b1;
      data_addr   = 32'h00000200;
      mem_addr_ok = 1'b1;
      mem_data_ok = 1'b1;
      for (int k = 0; k < 4; k++) begin
         logic exp_d;
         exp_d = (k % 2 == 0);
         #1;
         check("c_grant", {data_addr_ok, inst_addr_ok}, exp_d ? 2'b10 : 2'b01);
         tick();
         mem_rdata = 32'hA5A50000 + k;
         #1;
         check("c_issue_addr", mem_addr, exp_d ? 32'h200 : 32'h100);
         check("c_issue_nogrant", {mem_req, data_addr_ok, inst_addr_ok}, 3'b100);
         tick();
         #1;
         check("c_resp", {data_data_ok, inst_data_ok, data_addr_ok, inst_addr_ok},
               exp_d ? 4'b1000 : 4'b0100);
         check("c_rdata", exp_d ? data_rdata : inst_rdata, 32'hA5A50000 + k);
         tick();
      end

      // back-pressure: last grant was INST, so DATA wins this collision
      idle_inputs();
      inst_req  = 1'b1;
      inst_addr = 32'h00000300;
      data_req  = 1'b1;
      data_addr = 32'h80002000;
      #1;
      check("b_grant", {data_addr_ok, inst_addr_ok}, 2'b10);
      tick();
      data_req  = 1'b0;
      data_addr = '0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("b_hold", {mem_req, data_addr_ok, inst_addr_ok}, 3'b100);
         check("b_addr", mem_addr, 32'h80002000);
         tick();
      end
      mem_addr_ok = 1'b1;
      #1;
      check("b_accept_req", mem_req, 1'b1);
      tick();
      mem_addr_ok = 1'b0;
      #1;
      check("b_wait_nogrant", {data_addr_ok, inst_addr_ok}, 2'b00);
      mem_data_ok = 1'b1;
      mem_rdata   = 32'h12345678;
      tick();
      mem_data_ok = 1'b0;
      mem_rdata   = '0;
      #1;
      check("b_resp", {data_data_ok, inst_data_ok, inst_addr_ok}, 3'b100);
      check("b_rdata", data_rdata, 32'h12345678);
      tick();
      #1;
      check("b_next_inst", {data_addr_ok, inst_addr_ok}, 2'b01);

      // reset while the fetch waits in WAIT, then a stray data_ok in IDLE
      tick();
      inst_req    = 1'b0;
      mem_addr_ok = 1'b1;
      tick();
      mem_addr_ok = 1'b0;
      #1;
      check("r_in_wait", mem_req, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mem_addr_ok = 1'b1;
      mem_data_ok = 1'b1;
      mem_rdata   = 32'h77777777;
      #1;
      check("r_idle_quiet", {mem_req, data_addr_ok, inst_addr_ok}, 3'b000);
      tick();
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      mem_rdata   = '0;
      #1;
      check("r_no_data_ok", {data_data_ok, inst_data_ok, mem_req}, 3'b000);
      check("r_rdata_cleared", inst_rdata, 32'h0);
      inst_req  = 1'b1;
      inst_addr = 32'h00000400;
      #1;
      check("r_inst_accept", inst_addr_ok, 1'b1);
      tick();
      inst_req    = 1'b0;
      mem_addr_ok = 1'b1;
      mem_data_ok = 1'b1;
      mem_rdata   = 32'hCAFEF00D;
      #1;
      check("r_mem_addr", mem_addr, 32'h400);
      tick();
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      #1;
      check("r_inst_resp", {data_data_ok, inst_data_ok}, 2'b01);
      check("r_inst_rdata", inst_rdata, 32'hCAFEF00D);
      tick();
      inst_req  = 1'b1;
      data_req  = 1'b1;
      data_addr = 32'h00000500;
      #1;
      check("r_collide_data", {data_addr_ok, inst_addr_ok}, 2'b10);
      tick();
      idle_inputs();
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mycpu_mem_arbiter.md
Name: mycpu_mem_arbiter

Overview:
- Arbitrates the single shared SRAM-like memory port between the fetch stage and the memory stage of the myCPU pipeline.
- The fetch stage is a read-only requester that supplies the PC as the address. The memory stage is a read/write requester.
- Only one transaction is in flight at a time. Grants alternate round-robin on collision.
- Every request is answered with a two-phase handshake: addr_ok first, then data_ok.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory port.
- DATA_W, 32, data width. The write strobe width is DATA_W/8.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_req  in  1  fetch request; held with inst_addr until inst_addr_ok.
- inst_addr  in  ADDR_W  fetch address (the PC).
- inst_addr_ok  out  1  fetch request accepted (1-cycle pulse).
- inst_data_ok  out  1  fetch data valid (1-cycle pulse).
- inst_rdata  out  DATA_W  fetched instruction word.
- data_req  in  1  memory-stage request; held with its fields until data_addr_ok.
- data_wr  in  1  1 = write, 0 = read.
- data_wstrb  in  DATA_W/8  byte enables for writes.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  write data.
- data_addr_ok  out  1  data request accepted (1-cycle pulse).
- data_data_ok  out  1  data transaction complete (1-cycle pulse).
- data_rdata  out  DATA_W  read data.
- mem_req  out  1  request to memory; held until mem_addr_ok.
- mem_wr  out  1  write flag.
- mem_wstrb  out  DATA_W/8  byte enables.
- mem_addr  out  ADDR_W  address.
- mem_wdata  out  DATA_W  write data.
- mem_addr_ok  in  1  memory accepted the request.
- mem_data_ok  in  1  memory completed the transaction.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset values: state=IDLE, mem_req=0, all *_addr_ok and *_data_ok = 0, inst_rdata=0, data_rdata=0, last_grant=INST. All mem_* field registers reset to 0.
- FSM states are IDLE, ISSUE, WAIT and RESP.
- IDLE, acceptance:
  - If any *_req is high, choose a winner and assert the winner's *_addr_ok combinationally in the same cycle.
  - Latch addr/wr/wstrb/wdata into the mem_* registers, record the owner, update last_grant, and go to ISSUE.
  - Fetch requests always latch wr=0, wstrb=0 and wdata=0.
- Winner selection:
  - If only one requester is active, it wins.
  - If both are active, the requester not equal to last_grant wins. After reset, a collision therefore goes to DATA first.
- ISSUE:
  - mem_req=1 and mem_* are driven from the registers, stable for the whole state.
  - On mem_addr_ok=1: if mem_data_ok=1 in the same cycle, capture the response and go to RESP; otherwise go to WAIT.
  - mem_data_ok without mem_addr_ok is ignored.
- WAIT: mem_req=0. On mem_data_ok, capture the response and go to RESP.
- Response capture:
  - For reads, mem_rdata goes to the owner's rdata register. For writes, the owner's rdata register is loaded with 0.
  - The non-owner's rdata register is unchanged.
- RESP:
  - The owner's *_data_ok is 1 for exactly this one cycle, with its rdata valid and then held until that owner's next completion.
  - Next state is IDLE. No new request is accepted in RESP.
- Minimum latency:
  - acceptance at cycle 0,
  - mem_req at cycle 1,
  - data_ok at cycle 2 when memory answers addr_ok and data_ok together.
- *_addr_ok is never asserted outside IDLE. At most one *_addr_ok and at most one *_data_ok is high in any cycle.
- A requester dropping *_req before its addr_ok is legal and is simply not granted. Requester signals are sampled only in IDLE.
- Reset mid-operation (any state):
  - The next state is IDLE with the reset values above, and the in-flight transaction is dropped.
  - A stray mem_data_ok/mem_addr_ok arriving in IDLE is ignored and produces no *_data_ok.
- Fairness: under continuous dual requests, grants strictly alternate DATA, INST, DATA, ...

Decomposition:
- Package mycpu_mem_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP),
  - the requester ID constants (INST=0, DATA=1),
  - the default widths.
- Sub-module mycpu_rr_arb2: a combinational 2-way round-robin pick that takes the two requests and last_grant and returns a one-hot grant. The last_grant register stays in the parent.

Test Plan:
- Single fetch: inst_req=1, inst_addr=0xBFC00000; memory gives addr_ok in cycle 1 and data_ok in cycle 3 with rdata=0x24080001 -> inst_addr_ok in cycle 0, mem_addr=0xBFC00000 with mem_wr=0, inst_data_ok in cycle 4 with inst_rdata=0x24080001.
- Data write: data_req=1, wr=1, wstrb=0xF, addr=0x80001000, wdata=0xDEADBEEF -> mem_* carry the same values; data_data_ok pulses once with data_rdata=0; inst_rdata unchanged.
- Collision after reset: both requests held continuously for 4 transactions -> grant order DATA, INST, DATA, INST, with one transaction in flight at a time.
- Zero-wait memory: mem_addr_ok and mem_data_ok both high in cycle 1 -> data_ok in cycle 2; the next acceptance is at the earliest in cycle 3.
- Back-pressure: mem_addr_ok held low for 5 cycles -> mem_req stays 1 and mem_addr is stable for all 5 cycles; no *_addr_ok is asserted during this time.
- Reset in WAIT: assert rst for 1 cycle, then mem_data_ok=1 arrives in IDLE -> no *_data_ok; the next inst_req is accepted normally, and a collision goes to DATA first.
